// File: rtl/mmul_stream_ctrl.sv
// Stream front/back end for one mmul instance: loads A then B element by element,
// runs mmul, then drains the captured product as a valid/ready stream.
module mmul_stream_ctrl #(
  parameter int M     = 3,
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int L     = 3,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   error,
  output logic [M*N*WIDTH-1:0]   mm_mat_a,
  output logic [K*L*WIDTH-1:0]   mm_mat_b,
  output logic                   mm_enable,
  input  logic [M*L*WIDTH-1:0]   mm_mat_axb,
  input  logic                   mm_done,
  input  logic                   mm_invalid
);
  localparam int NA  = M * N;
  localparam int NB  = K * L;
  localparam int NR  = M * L;
  localparam int NMX = (NA > NB) ? NA : NB;
  localparam int IW  = $clog2(NMX + 1);
  localparam int RW  = $clog2(NR + 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, RUN, DRAIN, ERR} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx;
  logic [RW-1:0]       ridx;
  logic [NR*WIDTH-1:0] result;
  logic                a_last, b_last, r_last;
  logic                in_xfer, out_xfer;

  assign a_last   = (idx == IW'(NA - 1));
  assign b_last   = (idx == IW'(NB - 1));
  assign r_last   = (ridx == RW'(NR - 1));
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_A;
    else       state <= state_nx;
  end

  // in_ready is masked by reset so it stays low while reset is held.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = !reset;
        if (in_valid && a_last) state_nx = LOAD_B;
      end
      LOAD_B: begin
        in_ready = !reset;
        if (in_valid && b_last) state_nx = RUN;
      end
      RUN: begin
        if (mm_invalid)   state_nx = ERR;
        else if (mm_done) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && r_last) state_nx = LOAD_A;
      end
      ERR:     state_nx = ERR;
      default: state_nx = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      ridx      <= '0;
      result    <= '0;
      mm_mat_a  <= '0;
      mm_mat_b  <= '0;
      mm_enable <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (in_xfer) begin
          mm_mat_a[int'(idx)*WIDTH +: WIDTH] <= in_data;
          idx <= a_last ? '0 : idx + 1'b1;
        end
        LOAD_B: if (in_xfer) begin
          mm_mat_b[int'(idx)*WIDTH +: WIDTH] <= in_data;
          idx <= b_last ? '0 : idx + 1'b1;
          if (b_last) mm_enable <= 1'b1;
        end
        // invalid wins over done when both arrive together
        RUN: begin
          if (mm_invalid) begin
            mm_enable <= 1'b0;
            error     <= 1'b1;
          end else if (mm_done) begin
            result    <= mm_mat_axb;
            mm_enable <= 1'b0;
            ridx      <= '0;
          end
        end
        DRAIN: if (out_xfer) ridx <= r_last ? '0 : ridx + 1'b1;
        default: ;
      endcase
    end
  end

  assign out_data = (state == DRAIN) ? result[int'(ridx)*WIDTH +: WIDTH] : '0;
  assign out_last = (state == DRAIN) && r_last;

endmodule

// File: tb/tb_mmul_stream_ctrl.sv
// Directed bench for mmul_stream_ctrl with a behavioural mmul that raises done
// (optionally with invalid) a fixed number of cycles after enable.
module tb_mmul_stream_ctrl;
  localparam int W  = 8;
  localparam int VW = 9 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic          out_last, error;
  logic [VW-1:0] mm_mat_a, mm_mat_b;
  logic          mm_enable;
  logic [VW-1:0] mm_mat_axb = '0;
  logic          mm_done    = 1'b0;
  logic          mm_invalid = 1'b0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int mcnt     = 0;
  bit inv_mode = 1'b0;

  int a_nom[9] = '{1, 2, 3, 1, 0, 5, 3, 8, 2};
  int b_nom[9] = '{0, 0, 3, 5, 6, 1, 2, 0, 8};
  int a_id[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int p_nom[9] = '{16, 12, 29, 10, 0, 43, 44, 48, 33};
  int p_id[9]  = '{0, 0, 3, 5, 6, 1, 2, 0, 8};

  mmul_stream_ctrl #(.M(3), .N(3), .K(3), .L(3), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .error(error),
    .mm_mat_a(mm_mat_a), .mm_mat_b(mm_mat_b), .mm_enable(mm_enable),
    .mm_mat_axb(mm_mat_axb), .mm_done(mm_done), .mm_invalid(mm_invalid)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mul(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'(a[(i*3+k)*W +: W]) * int'(b[(k*3+j)*W +: W]);
        r[(i*3+j)*W +: W] = 8'(s);
      end
    return r;
  endfunction

  function automatic logic [VW-1:0] pack(input int v[9]);
    logic [VW-1:0] r;
    r = '0;
    for (int s = 0; s < 9; s++) r[s*W +: W] = 8'(v[s]);
    return r;
  endfunction

  // Behavioural mmul: updates on the falling edge, done 5 cycles after enable.
  always @(negedge clk) begin
    if (mm_enable !== 1'b1) begin
      mcnt = 0; mm_done = 1'b0; mm_invalid = 1'b0;
    end else begin
      mcnt++;
      if (mcnt == 5) begin
        mm_mat_axb = mul(mm_mat_a, mm_mat_b);
        mm_done    = 1'b1;
        mm_invalid = inv_mode;
      end
    end
  end

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    chk("rst_in_ready", VW'(in_ready), 0);
    chk("rst_out_valid", VW'(out_valid), 0);
    chk("rst_out_data", VW'(out_data), 0);
    chk("rst_out_last", VW'(out_last), 0);
    chk("rst_error", VW'(error), 0);
    chk("rst_mm_enable", VW'(mm_enable), 0);
    chk("rst_mat_a", mm_mat_a, 0);
    chk("rst_mat_b", mm_mat_b, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready_after", VW'(in_ready), 1);
  endtask

  task automatic send(input int d, input bit gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    while (!in_ready && n < 50) begin step(); n++; end
    if (n == 50) chk("in_ready_wait", VW'(in_ready), 1);
    step();
    in_valid = 1'b0;
    if (gap) step();
  endtask

  task automatic load(input int a[9], input int b[9], input bit gap);
    for (int s = 0; s < 9; s++) send(a[s], gap);
    for (int s = 0; s < 9; s++) send(b[s], gap && s < 8);
    chk("run_mm_enable", VW'(mm_enable), 1);
    chk("run_in_ready", VW'(in_ready), 0);
  endtask

  task automatic recv(input int exp[9], input int hold_at, input int cnt);
    int n;
    for (int r = 0; r < cnt; r++) begin
      if (r == hold_at) out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin step(); n++; end
      if (n == 50) chk("out_valid_wait", VW'(out_valid), 1);
      chk("out_data", VW'(out_data), VW'(exp[r]));
      chk("out_last", VW'(out_last), VW'(r == 8));
      chk("drain_mm_enable", VW'(mm_enable), 0);
      if (r == hold_at) begin
        for (int h = 0; h < 3; h++) begin
          step();
          chk("hold_valid", VW'(out_valid), 1);
          chk("hold_data", VW'(out_data), VW'(exp[r]));
        end
        out_ready = 1'b1;
      end
      step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    do_reset();

    // nominal run, then immediately a back-to-back identity run
    load(a_nom, b_nom, 1'b0);
    chk("nom_mat_a", mm_mat_a, pack(a_nom));
    chk("nom_mat_b", mm_mat_b, pack(b_nom));
    recv(p_nom, -1, 9);
    chk("b2b_in_ready", VW'(in_ready), 1);
    load(a_id, b_nom, 1'b0);
    recv(p_id, -1, 9);

    // input gaps plus output stall on element 4
    load(a_nom, b_nom, 1'b1);
    chk("gap_mat_a", mm_mat_a, pack(a_nom));
    chk("gap_mat_b", mm_mat_b, pack(b_nom));
    recv(p_nom, 4, 9);

    // invalid alongside done: sticky error until reset
    inv_mode = 1'b1;
    load(a_nom, b_nom, 1'b0);
    for (int n = 0; n < 50 && !error; n++) step();
    chk("inv_error", VW'(error), 1);
    chk("inv_mm_enable", VW'(mm_enable), 0);
    chk("inv_out_valid", VW'(out_valid), 0);
    in_valid = 1'b1;
    for (int h = 0; h < 3; h++) begin
      step();
      chk("err_in_ready", VW'(in_ready), 0);
      chk("err_out_valid", VW'(out_valid), 0);
      chk("err_sticky", VW'(error), 1);
    end
    in_valid = 1'b0;
    inv_mode = 1'b0;
    do_reset();
    load(a_nom, b_nom, 1'b0);
    recv(p_nom, -1, 9);

    // reset after four outputs, then a clean identity run
    load(a_nom, b_nom, 1'b0);
    recv(p_nom, -1, 4);
    do_reset();
    step();
    chk("post_rst_out_valid", VW'(out_valid), 0);
    load(a_id, b_nom, 1'b0);
    recv(p_id, -1, 9);

    if (fail_cnt > 0) $display("%0d error lines above", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
